// File: rtl/rgb_fade_seq.sv
// Colour-table sequencer: steps three 8-bit PWM duty values one count per tick
// toward each table entry in turn, holds there, then advances, loops or finishes.
module rgb_fade_seq #(
  parameter int STEP_DIV   = 256,
  parameter int HOLD_STEPS = 64
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        stop,
  input  logic        loop,
  input  logic [2:0]  last_idx,
  input  logic        wr_en,
  input  logic [2:0]  wr_addr,
  input  logic [23:0] wr_data,
  output logic [7:0]  value0,
  output logic [7:0]  value1,
  output logic [7:0]  value2,
  output logic        en_out,
  output logic        busy,
  output logic        done
);

  localparam int            PW   = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(STEP_DIV - 1);
  localparam logic [7:0]    HMAX = 8'(HOLD_STEPS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FADE,
    S_HOLD,
    S_DONE
  } state_t;

  state_t        r_state;
  logic [2:0]    r_idx;
  logic [PW-1:0] r_presc;
  logic [7:0]    r_hold;
  logic [7:0]    r_tgt0, r_tgt1, r_tgt2;
  logic [23:0]   r_table [8];

  logic          w_tick;
  logic [7:0]    w_next0, w_next1, w_next2;
  logic          w_arrived;
  logic [23:0]   w_entry;
  logic          w_match;

  function automatic logic [7:0] stepToward(input logic [7:0] v, input logic [7:0] t);
    if (v < t)      return v + 8'd1;
    else if (v > t) return v - 8'd1;
    else            return v;
  endfunction

  // The table survives reset, but a write coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (resetn && wr_en) r_table[wr_addr] <= wr_data;
  end

  assign w_tick    = (r_presc == PMAX);
  assign w_next0   = stepToward(value0, r_tgt0);
  assign w_next1   = stepToward(value1, r_tgt1);
  assign w_next2   = stepToward(value2, r_tgt2);
  assign w_arrived = (w_next0 == r_tgt0) && (w_next1 == r_tgt1) && (w_next2 == r_tgt2);
  assign w_entry   = r_table[r_idx];
  assign w_match   = ({value0, value1, value2} == w_entry);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_idx   <= 3'd0;
      r_presc <= '0;
      r_hold  <= 8'd0;
      r_tgt0  <= 8'd0;
      r_tgt1  <= 8'd0;
      r_tgt2  <= 8'd0;
      value0  <= 8'd0;
      value1  <= 8'd0;
      value2  <= 8'd0;
      en_out  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      en_out <= 1'b0;
      if (stop) begin
        r_state <= S_IDLE;
        r_presc <= '0;
        r_hold  <= 8'd0;
        busy    <= 1'b0;
        done    <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE, S_DONE: begin
            if (start) begin
              r_idx   <= 3'd0;
              r_state <= S_LOAD;
              busy    <= 1'b1;
              done    <= 1'b0;
            end
          end
          // Target is read before this edge's table write lands, so old data wins.
          S_LOAD: begin
            r_tgt0  <= w_entry[23:16];
            r_tgt1  <= w_entry[15:8];
            r_tgt2  <= w_entry[7:0];
            r_presc <= '0;
            r_hold  <= 8'd0;
            r_state <= w_match ? S_HOLD : S_FADE;
          end
          S_FADE: begin
            r_presc <= w_tick ? '0 : r_presc + 1'b1;
            if (w_tick) begin
              value0 <= w_next0;
              value1 <= w_next1;
              value2 <= w_next2;
              en_out <= 1'b1;
              if (w_arrived) begin
                r_state <= S_HOLD;
                r_hold  <= 8'd0;
              end
            end
          end
          S_HOLD: begin
            r_presc <= w_tick ? '0 : r_presc + 1'b1;
            if (w_tick) begin
              if (r_hold == HMAX) begin
                r_hold <= 8'd0;
                if (r_idx < last_idx) begin
                  r_idx   <= r_idx + 3'd1;
                  r_state <= S_LOAD;
                end else if (loop) begin
                  r_idx   <= 3'd0;
                  r_state <= S_LOAD;
                end else begin
                  r_state <= S_DONE;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                end
              end else begin
                r_hold <= r_hold + 8'd1;
              end
            end
          end
          default: begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rgb_fade_seq.sv
// Directed bench for rgb_fade_seq with STEP_DIV=4, HOLD_STEPS=2; cycle n means
// the outputs seen after the n-th rising edge following the start request.
module tb_rgb_fade_seq;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        loop = 1'b0;
  logic [2:0]  last_idx = 3'd0;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_addr = 3'd0;
  logic [23:0] wr_data = 24'd0;
  logic [7:0]  value0, value1, value2;
  logic        en_out, busy, done;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic       st;
    logic       sp;
    logic       en;
    logic [7:0] v0, v1, v2;
    logic       bsy, dn;
  } vec_t;

  vec_t ramp[25];

  rgb_fade_seq #(.STEP_DIV(4), .HOLD_STEPS(2)) dut (
    .clk(clk), .resetn(resetn), .start(start), .stop(stop), .loop(loop),
    .last_idx(last_idx), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .value0(value0), .value1(value1), .value2(value2),
    .en_out(en_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Inputs change at the falling edge; outputs are sampled at the next falling edge.
  task automatic applyStimulus(input logic s, input logic p);
    start = s;
    stop  = p;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic e_en, input logic [7:0] e0,
                             input logic [7:0] e1, input logic [7:0] e2,
                             input logic e_busy, input logic e_done);
    total++;
    if ({en_out, value0, value1, value2, busy, done} !== {e_en, e0, e1, e2, e_busy, e_done}) begin
      bad++;
      $display("[TB] FAIL %s: got en=%0b v=%h,%h,%h busy=%0b done=%0b, want en=%0b v=%h,%h,%h busy=%0b done=%0b",
               name, en_out, value0, value1, value2, busy, done, e_en, e0, e1, e2, e_busy, e_done);
    end
  endtask

  task automatic checkVal(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, got, exp);
    end
  endtask

  task automatic writeEntry(input logic [2:0] a, input logic [23:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    applyStimulus(1'b0, 1'b0);
    wr_en = 1'b0;
  endtask

  task automatic doReset();
    resetn = 1'b0;
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    resetn = 1'b1;
  endtask

  initial begin
    int pulses;
    int errs;
    int pulseCyc[$];
    logic [7:0] pulseVal[$];
    int expCyc[5];
    logic [7:0] expV[5];

    for (int k = 0; k < 25; k++) begin
      ramp[k].st  = (k == 0);
      ramp[k].sp  = 1'b0;
      ramp[k].en  = (k == 5) || (k == 9) || (k == 13);
      ramp[k].v0  = (k < 5) ? 8'd0 : (k < 9) ? 8'd1 : (k < 13) ? 8'd2 : 8'd3;
      ramp[k].v1  = (k < 5) ? 8'd0 : 8'd1;
      ramp[k].v2  = 8'd0;
      ramp[k].bsy = (k <= 20);
      ramp[k].dn  = (k >= 21);
    end
    expCyc = '{6, 10, 23, 27, 40};
    expV   = '{8'd1, 8'd2, 8'd1, 8'd0, 8'd1};

    @(negedge clk);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("reset_init", 0, 8'd0, 8'd0, 8'd0, 0, 0);
    resetn = 1'b1;

    // Single ramp to 0x030100
    writeEntry(3'd0, 24'h030100);
    for (int k = 0; k < 25; k++) begin
      applyStimulus(ramp[k].st, ramp[k].sp);
      checkOutput($sformatf("ramp_c%0d", k + 1), ramp[k].en, ramp[k].v0, ramp[k].v1,
                  ramp[k].v2, ramp[k].bsy, ramp[k].dn);
    end

    // Stop from DONE, then start+stop together must stay idle
    applyStimulus(1'b0, 1'b1);
    checkOutput("stop_from_done", 0, 8'd3, 8'd1, 8'd0, 0, 0);
    applyStimulus(1'b1, 1'b1);
    checkOutput("start_stop_same", 0, 8'd3, 8'd1, 8'd0, 0, 0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("start_stop_after", 0, 8'd3, 8'd1, 8'd0, 0, 0);

    // Target equals current values; a second start mid-hold is ignored
    pulses = 0;
    for (int c = 1; c <= 10; c++) begin
      applyStimulus((c == 1) || (c == 4), 1'b0);
      if (en_out) pulses++;
      if (c == 1)  checkOutput("eq_load", 0, 8'd3, 8'd1, 8'd0, 1, 0);
      if (c == 9)  checkOutput("eq_hold_end", 0, 8'd3, 8'd1, 8'd0, 1, 0);
      if (c == 10) checkOutput("eq_done", 0, 8'd3, 8'd1, 8'd0, 0, 1);
    end
    checkVal("eq_no_pulses", pulses, 0);

    // Mid-fade reset beats start and a table write
    writeEntry(3'd0, 24'h050000);
    for (int c = 1; c <= 7; c++) begin
      applyStimulus(c == 1, 1'b0);
      if (c == 6) checkOutput("pre_rst_pulse", 1, 8'd4, 8'd0, 8'd0, 1, 0);
    end
    resetn = 1'b0; wr_en = 1'b1; wr_addr = 3'd0; wr_data = 24'hFFFFFF;
    applyStimulus(1'b1, 1'b0);
    checkOutput("rst_mid_1", 0, 8'd0, 8'd0, 8'd0, 0, 0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("rst_mid_2", 0, 8'd0, 8'd0, 8'd0, 0, 0);
    resetn = 1'b1; wr_en = 1'b0;
    applyStimulus(1'b0, 1'b0);
    checkOutput("rst_release", 0, 8'd0, 8'd0, 8'd0, 0, 0);

    // Stop after value0 reaches 2, then resume from 2 (table kept 0x050000)
    for (int c = 1; c <= 10; c++) begin
      applyStimulus(c == 1, 1'b0);
      if (c == 6)  checkOutput("stop_p1", 1, 8'd1, 8'd0, 8'd0, 1, 0);
      if (c == 10) checkOutput("stop_p2", 1, 8'd2, 8'd0, 8'd0, 1, 0);
    end
    applyStimulus(1'b0, 1'b1);
    checkOutput("stop_idle", 0, 8'd2, 8'd0, 8'd0, 0, 0);
    errs = 0;
    for (int c = 0; c < 10; c++) begin
      applyStimulus(1'b0, 1'b0);
      if (en_out || value0 != 8'd2 || busy) errs++;
    end
    checkVal("stop_quiet", errs, 0);
    for (int c = 1; c <= 6; c++) applyStimulus(c == 1, 1'b0);
    checkOutput("resume_p1", 1, 8'd3, 8'd0, 8'd0, 1, 0);
    applyStimulus(1'b0, 1'b1);

    // Loop across two entries with a down-fade
    doReset();
    writeEntry(3'd0, 24'h020000);
    writeEntry(3'd1, 24'h000000);
    last_idx = 3'd1; loop = 1'b1;
    errs = 0;
    for (int c = 1; c <= 42; c++) begin
      applyStimulus(c == 1, 1'b0);
      if (en_out) begin
        pulseCyc.push_back(c);
        pulseVal.push_back(value0);
      end
      if (busy !== 1'b1 || done !== 1'b0) errs++;
    end
    checkVal("loop_busy", errs, 0);
    checkVal("loop_pulse_count", pulseCyc.size(), 5);
    for (int i = 0; i < 5 && i < pulseCyc.size(); i++) begin
      checkVal($sformatf("loop_cyc%0d", i), pulseCyc[i], expCyc[i]);
      checkVal($sformatf("loop_v0_%0d", i), int'(pulseVal[i]), int'(expV[i]));
    end
    applyStimulus(1'b0, 1'b1);

    // Write to the entry being loaded: old colour now, new colour next visit
    doReset();
    writeEntry(3'd0, 24'h010000);
    last_idx = 3'd0; loop = 1'b1;
    for (int c = 1; c <= 19; c++) begin
      if (c == 2) begin
        wr_en = 1'b1; wr_addr = 3'd0; wr_data = 24'h000001;
      end
      applyStimulus(c == 1, 1'b0);
      wr_en = 1'b0;
      if (c == 6)  checkOutput("coll_old", 1, 8'd1, 8'd0, 8'd0, 1, 0);
      if (c == 19) checkOutput("coll_new", 1, 8'd0, 8'd0, 8'd1, 1, 0);
    end
    applyStimulus(1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
